bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD counter extending the single-digit decade counter. It supports a configurable digit count, up/down direction, count enable, synchronous parallel load, and a selectable wrap or saturate mode. A combinational terminal-count output allows wider counters to be cascaded, and a registered overflow pulse flags boundary events. It is intended for lab display/timer datapaths such as stopwatch seconds/minutes and event tallies driving 7-segment decoders.

## Interface
- DIGITS, 2, number of BCD digits (1..8); counter width is 4*DIGITS bits
- WRAP, 1, 1 = wrap at the boundaries (99..9 <-> 00..0); 0 = saturate at the boundaries
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; one step per clk while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load; has priority over en
- load_val  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i]
- q  output  4*DIGITS  current count in BCD, registered; digit 0 is least significant
- tc  output  1  combinational terminal count = en & (up ? q==all-9s : q==all-0s); drives the en input of a cascaded stage
- ovf  output  1  registered one-cycle pulse: a boundary step was taken or attempted on the previous edge

## Operation
- Every digit of q always holds a value in 0..9. No illegal BCD code can appear on q.
- Priority per rising edge: load, then en. With load=0 and en=0, q holds and ovf is cleared.
- Load:
  - q <= load_val, with any digit >9 clamped to 9 (for example 0xA3 loads as 0x93).
  - ovf <= 0, regardless of en and up.
- Increment (en=1, up=1, load=0):
  - Digit 0 adds 1.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - A digit at 9 carries only when all lower digits are 9.
- Decrement (en=1, up=0, load=0):
  - Digit 0 subtracts 1.
  - A digit at 0 rolls to 9 and borrows from the next digit.
- Boundaries:
  - Up at all-9s: q <= 0 if WRAP=1; q holds if WRAP=0. In both cases ovf <= 1.
  - Down at all-0s: q <= all-9s if WRAP=1; q holds if WRAP=0. In both cases ovf <= 1.
- ovf is 0 on every edge that is not a boundary step.
- tc is purely combinational from en, up and q. It asserts in the same cycle that the boundary step is pending, whatever the value of load.
- Changing direction takes effect on the next edge. There is no hysteresis or extra state.

## Timing
- Reset:
  - rst_n low forces q=0 and ovf=0 immediately, with no clock needed. This holds at any point, including mid-count or during a load.
  - Release is synchronous to the design (two-flop synchroniser upstream, outside this block).
  - The first count edge is the first rising clk after rst_n is high.
- Latency:
  - q reflects load or a count step one clk after sampling.
  - ovf asserts in the same cycle the boundary value appears on q (or the held value, when saturating).
- tc has zero latency. Cascaded stages share clk, and the upper stage's en is tied to the lower stage's tc. Together they must behave as a single counter with DIGITS summed.
- Simultaneous load=1 and en=1: the load wins, no count step occurs, and ovf=0.
- Single clock domain. There are no multicycle paths, and the carry chain is combinational across all digits within one cycle.

## Test plan
- Reset mid-count: DIGITS=2; count to 0x37, then assert rst_n=0 between edges -> q=0x00 and ovf=0 immediately. After release with en=1 -> 0x01 on the first edge.
- Decimal roll-over, up: DIGITS=2, WRAP=1, load 0x97, then 4 edges with en=1, up=1 -> q = 0x98, 0x99, 0x00, 0x01.
  - tc=1 only while q=0x99.
  - ovf=1 only in the cycle q=0x00.
- Down and saturate: DIGITS=2, WRAP=0, load 0x02, then 4 edges with en=1, up=0 -> q = 0x01, 0x00, 0x00, 0x00.
  - ovf=1 on the third and fourth edges.
- Borrow chain: DIGITS=3, load 0x100, then one edge with up=0 -> q=0x099. One further edge with up=1 -> q=0x100.
- Load priority and clamping: load=1, en=1, load_val=0xB5 -> q=0x95 and ovf=0. Then en=0 for 3 edges -> q stays 0x95.
- Cascade: two DIGITS=1 instances, the upper stage's en tied to the lower stage's tc, start at 0x00 with up=1 -> after 100 edges the pair reads 00 again. The upper stage's ovf pulses once.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate boundaries,
// a combinational terminal count for cascading and a registered overflow pulse.
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                ovf
);

    localparam int             W         = 4 * DIGITS;
    localparam logic [W-1:0]   ALL_NINES = {DIGITS{4'h9}};

    logic [W-1:0] q_d, q_q;
    logic         ovf_d, ovf_q;
    logic         at_max, at_min;
    logic         carry;
    logic [3:0]   digit;

    assign at_max = (q_q == ALL_NINES);
    assign at_min = (q_q == '0);
    // tc deliberately ignores load so a cascaded stage sees the pending boundary.
    assign tc     = en & (up ? at_max : at_min);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        q_d   = q_q;
        ovf_d = 1'b0;
        carry = 1'b0;
        digit = '0;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit           = load_val[4*i +: 4];
                q_d[4*i +: 4]   = (digit > 4'd9) ? 4'd9 : digit;
            end
        end else if (tc) begin
            ovf_d = 1'b1;
            if (WRAP) begin
                q_d = up ? '0 : ALL_NINES;
            end
        end else if (en) begin
            // Ripple the carry/borrow from digit 0 until a digit absorbs it.
            carry = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                digit = q_q[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (digit == 4'd9) begin
                            q_d[4*i +: 4] = 4'd0;
                        end else begin
                            q_d[4*i +: 4] = digit + 4'd1;
                            carry         = 1'b0;
                        end
                    end else begin
                        if (digit == 4'd0) begin
                            q_d[4*i +: 4] = 4'd9;
                        end else begin
                            q_d[4*i +: 4] = digit - 4'd1;
                            carry         = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised and directed bench for bcd_updown_counter against an integer-valued
// reference model (counts kept as plain decimal integers, converted to BCD for compare).
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 2-digit wrap and 2-digit saturate instances
    logic       a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [7:0] a_lv = '0;
    logic [7:0] w_q, s_q;
    logic       w_tc, s_tc, w_ovf, s_ovf;

    // 3-digit instance
    logic        d_en = 1'b0, d_up = 1'b1, d_load = 1'b0;
    logic [11:0] d_lv = '0;
    logic [11:0] d_q;
    logic        d_tc, d_ovf;

    // Cascade of two 1-digit stages
    logic       c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_ovf, hi_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int mv_w = 0, mv_s = 0;   // model values of the two 2-digit instances

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_w2 (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .q(w_q), .tc(w_tc), .ovf(w_ovf));
    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_s2 (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .q(s_q), .tc(s_tc), .ovf(s_ovf));
    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .en(d_en), .up(d_up), .load(d_load),
        .load_val(d_lv), .q(d_q), .tc(d_tc), .ovf(d_ovf));
    bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .load(c_load),
        .load_val(4'h0), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf));
    bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(c_up), .load(c_load),
        .load_val(4'h0), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf));

    // ---------------- reference model ----------------
    function automatic int max_val(input int digits);
        int m = 0;
        for (int i = 0; i < digits; i++) m = m * 10 + 9;
        return m;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] r = '0;
        int          x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_load(input logic [31:0] lv, input int digits);
        int v = 0;
        int d;
        for (int i = digits - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic bit model_tc(input int v, input int digits, input bit en, input bit up);
        return en && (up ? (v == max_val(digits)) : (v == 0));
    endfunction

    function automatic bit model_ovf(input int v, input int digits, input bit en, input bit up,
                                     input bit load);
        return !load && model_tc(v, digits, en, up);
    endfunction

    function automatic int model_next(input int v, input int digits, input bit wrap, input bit en,
                                      input bit up, input bit load, input logic [31:0] lv);
        int m = max_val(digits);
        if (load) return clamp_load(lv, digits);
        if (!en) return v;
        if (up) return (v == m) ? (wrap ? 0 : m) : v + 1;
        return (v == 0) ? (wrap ? m : 0) : v - 1;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle on the shared 2-digit pair and advances both models (no checks here).
    task automatic a_drive(input bit en, input bit up, input bit load, input logic [7:0] lv,
                           output bit exp_tc_w, output bit exp_tc_s,
                           output bit exp_ovf_w, output bit exp_ovf_s);
        a_en = en; a_up = up; a_load = load; a_lv = lv;
        exp_tc_w  = model_tc(mv_w, 2, en, up);
        exp_tc_s  = model_tc(mv_s, 2, en, up);
        exp_ovf_w = model_ovf(mv_w, 2, en, up, load);
        exp_ovf_s = model_ovf(mv_s, 2, en, up, load);
        mv_w = model_next(mv_w, 2, 1'b1, en, up, load, {24'h0, lv});
        mv_s = model_next(mv_s, 2, 1'b0, en, up, load, {24'h0, lv});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] e;
        #3;
        n_tests++;
        if (w_q !== 8'h00 || w_ovf !== 1'b0 || d_q !== 12'h000 || lo_q !== 4'h0 || hi_q !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: w_q=%h ovf=%b d_q=%h lo=%h hi=%h, want all zero", w_q, w_ovf, d_q, lo_q, hi_q);
        end
        rst_n = 1'b1;
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 37; i++) clk_step();
        n_tests++;
        if (w_q !== 8'h37) begin
            n_fail++;
            $display("FAIL count_to_37: got %h want 37", w_q);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (w_q !== 8'h00 || w_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: q=%h ovf=%b want q=00 ovf=0", w_q, w_ovf);
        end
        #1 rst_n = 1'b1;
        mv_w = 0; mv_s = 0;
        clk_step();
        mv_w = 1; mv_s = 1;
        e = to_bcd(1, 2);
        n_tests++;
        if (w_q !== e[7:0] || s_q !== e[7:0]) begin
            n_fail++;
            $display("FAIL reset_release: w=%h s=%h want %h", w_q, s_q, e[7:0]);
        end
        a_en = 1'b0;
    endtask

    task automatic test_rollover_up();
        logic [7:0] exp_q  [4] = '{8'h98, 8'h99, 8'h00, 8'h01};
        bit         exp_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit         exp_tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit tw, ts, ow, os;
        a_drive(1'b0, 1'b1, 1'b1, 8'h97, tw, ts, ow, os);
        clk_step();
        for (int k = 0; k < 4; k++) begin
            a_drive(1'b1, 1'b1, 1'b0, 8'h00, tw, ts, ow, os);
            #1;
            n_tests++;
            if (w_tc !== exp_tc[k]) begin
                n_fail++;
                $display("FAIL rollover_tc[%0d]: got %b want %b", k, w_tc, exp_tc[k]);
            end
            clk_step();
            n_tests++;
            if (w_q !== exp_q[k] || w_ovf !== exp_ov[k]) begin
                n_fail++;
                $display("FAIL rollover_q[%0d]: q=%h ovf=%b want q=%h ovf=%b", k, w_q, w_ovf, exp_q[k], exp_ov[k]);
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_saturate_down();
        logic [7:0] exp_q  [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        bit         exp_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] e;
        bit tw, ts, ow, os;
        a_drive(1'b0, 1'b0, 1'b1, 8'h02, tw, ts, ow, os);
        clk_step();
        for (int k = 0; k < 4; k++) begin
            a_drive(1'b1, 1'b0, 1'b0, 8'h00, tw, ts, ow, os);
            clk_step();
            e = to_bcd(mv_w, 2);
            n_tests++;
            if (s_q !== exp_q[k] || s_ovf !== exp_ov[k]) begin
                n_fail++;
                $display("FAIL saturate_q[%0d]: q=%h ovf=%b want q=%h ovf=%b", k, s_q, s_ovf, exp_q[k], exp_ov[k]);
            end
            n_tests++;
            if (w_q !== e[7:0] || w_ovf !== ow) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: q=%h ovf=%b want q=%h ovf=%b", k, w_q, w_ovf, e[7:0], ow);
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_borrow_chain();
        d_load = 1'b1; d_lv = 12'h100;
        clk_step();
        d_load = 1'b0; d_en = 1'b1; d_up = 1'b0;
        clk_step();
        n_tests++;
        if (d_q !== 12'h099 || d_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_chain: q=%h ovf=%b want 099/0", d_q, d_ovf);
        end
        d_up = 1'b1;
        clk_step();
        n_tests++;
        if (d_q !== 12'h100 || d_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_chain: q=%h ovf=%b want 100/0", d_q, d_ovf);
        end
        d_en = 1'b0;
    endtask

    task automatic test_load_priority();
        bit tw, ts, ow, os;
        a_drive(1'b0, 1'b1, 1'b1, 8'h99, tw, ts, ow, os);
        clk_step();
        a_drive(1'b1, 1'b1, 1'b1, 8'hB5, tw, ts, ow, os);
        #1;
        n_tests++;
        if (w_tc !== 1'b1) begin
            n_fail++;
            $display("FAIL tc_during_load: got %b want 1", w_tc);
        end
        clk_step();
        n_tests++;
        if (w_q !== 8'h95 || w_ovf !== 1'b0 || s_q !== 8'h95 || s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: w=%h/%b s=%h/%b want 95/0", w_q, w_ovf, s_q, s_ovf);
        end
        for (int k = 0; k < 3; k++) begin
            a_drive(1'b0, 1'b1, 1'b0, 8'h00, tw, ts, ow, os);
            clk_step();
            n_tests++;
            if (w_q !== 8'h95 || w_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: q=%h ovf=%b want 95/0", k, w_q, w_ovf);
            end
        end
    endtask

    task automatic test_random();
        bit tw, ts, ow, os;
        logic [31:0] ew, es;
        int bad = 0;
        for (int k = 0; k < 300; k++) begin
            a_drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                    8'($urandom), tw, ts, ow, os);
            #1;
            n_tests++;
            if (w_tc !== tw || s_tc !== ts) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL random_tc[%0d]: w=%b s=%b want %b %b", k, w_tc, s_tc, tw, ts);
            end
            clk_step();
            ew = to_bcd(mv_w, 2);
            es = to_bcd(mv_s, 2);
            n_tests++;
            if (w_q !== ew[7:0] || w_ovf !== ow || s_q !== es[7:0] || s_ovf !== os) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL random_q[%0d]: w=%h/%b s=%h/%b want %h/%b %h/%b",
                             k, w_q, w_ovf, s_q, s_ovf, ew[7:0], ow, es[7:0], os);
            end
        end
        a_en = 1'b0; a_load = 1'b0;
    endtask

    task automatic test_cascade();
        int v = 0;
        int pulses = 0;
        logic [31:0] e;
        c_load = 1'b1;
        clk_step();
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        for (int k = 0; k < 100; k++) begin
            clk_step();
            v = (v + 1) % 100;
            e = to_bcd(v, 2);
            if (hi_ovf === 1'b1) pulses++;
            n_tests++;
            if ({hi_q, lo_q} !== e[7:0]) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got %h%h want %h", k, hi_q, lo_q, e[7:0]);
            end
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL cascade_ovf: got %0d pulses want 1", pulses);
        end
        c_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rollover_up();
        test_saturate_down();
        test_borrow_chain();
        test_load_priority();
        test_random();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
